// File: rtl/imem_pkg.sv
// Shared types, default widths and parity helper for the instruction memory controller.
package imem_pkg;

    localparam int unsigned IMEM_DATA_WIDTH = 16;
    localparam int unsigned IMEM_ADDR_WIDTH = 16;
    localparam int unsigned IMEM_DEPTH      = 256;
    localparam int unsigned PARITY_MAX_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } imem_state_e;

    // Even-parity bit: callers zero-extend narrower words to PARITY_MAX_W.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/imem_if.sv
// Load-channel and fetch-port bundle between loader/fetch stage (master) and controller (slave).
interface imem_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  ld_start;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_last;
    logic                  ld_done;
    logic [ADDR_WIDTH:0]   ld_count;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  fetch_err;
    logic                  fetch_perr;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, fetch_req, pc,
        input  ld_ready, ld_done, ld_count, fetch_valid, instruction, fetch_err, fetch_perr
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, fetch_req, pc,
        output ld_ready, ld_done, ld_count, fetch_valid, instruction, fetch_err, fetch_perr
    );
endinterface

// File: rtl/imem_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when not enabled.
module imem_sdp_ram #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data      <= mem[rd_addr];
    end
endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with streaming valid/ready loader and one-cycle fetch port.
// Optional feature macro: IMEM_PARITY_EN (even parity stored per word, checked on fetch).
module instr_mem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = IMEM_DEPTH
) (
    input logic   clk,
    input logic   rst_n,
    imem_if.slave bus
);
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int unsigned RAM_W  = DATA_WIDTH + 1;
`else
    localparam int unsigned RAM_W  = DATA_WIDTH;
`endif
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    imem_state_e      state_q, state_d;
    logic [CNT_W-1:0] ld_count_q, ld_count_d;
    logic             ld_ready_q, ld_ready_d;
    logic             ld_done_q, ld_done_d;
    logic             wr_en_c;
    logic             fetch_ok_c;
    logic             rd_en_c;
    logic             fetch_valid_q;
    logic             fetch_err_q;
    logic             instr_zero_q;
    logic [RAM_W-1:0] ram_wdata;
    logic [RAM_W-1:0] ram_rdata;

    // Load-session state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ld_count_q <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
            ld_ready_q <= ld_ready_d;
            ld_done_q  <= ld_done_d;
        end
    end

    // Next state; ld_start overrides everything, including a beat in flight.
    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        wr_en_c    = 1'b0;
        if (bus.ld_start) begin
            state_d    = LOAD;
            ld_count_d = '0;
        end else if (state_q == LOAD && bus.ld_valid && ld_ready_q) begin
            wr_en_c    = 1'b1;
            ld_count_d = ld_count_q + CNT_W'(1);
            if (bus.ld_last || ld_count_d == DEPTH_C) state_d = READY;
        end
        ld_ready_d = (state_d == LOAD) && (ld_count_d != DEPTH_C);
        ld_done_d  = (state_d == READY);
    end

    assign fetch_ok_c = (state_q == READY) && (CNT_W'(bus.pc) < DEPTH_C);
    assign rd_en_c    = bus.fetch_req && fetch_ok_c;

    // Fetch status; instr_zero_q forces and then holds a zero word after a rejected fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            instr_zero_q  <= 1'b1;
        end else begin
            fetch_valid_q <= bus.fetch_req;
            fetch_err_q   <= bus.fetch_req && !fetch_ok_c;
            if (bus.fetch_req) instr_zero_q <= !fetch_ok_c;
        end
    end

`ifdef IMEM_PARITY_EN
    logic rd_hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_hit_q <= 1'b0;
        else        rd_hit_q <= rd_en_c;
    end

    assign ram_wdata      = {even_parity(PARITY_MAX_W'(bus.ld_data)), bus.ld_data};
    assign bus.fetch_perr = rd_hit_q &&
        (even_parity(PARITY_MAX_W'(ram_rdata[DATA_WIDTH-1:0])) != ram_rdata[DATA_WIDTH]);
`else
    assign ram_wdata      = bus.ld_data;
    assign bus.fetch_perr = 1'b0;
`endif

    imem_sdp_ram #(
        .WIDTH  (RAM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (RAM_AW'(ld_count_q)),
        .wr_data (ram_wdata),
        .rd_en   (rd_en_c),
        .rd_addr (RAM_AW'(bus.pc)),
        .rd_data (ram_rdata)
    );

    assign bus.ld_ready    = ld_ready_q;
    assign bus.ld_done     = ld_done_q;
    assign bus.ld_count    = ld_count_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.instruction = instr_zero_q ? '0 : ram_rdata[DATA_WIDTH-1:0];
endmodule
